// File: rtl/team_06_wb_sram_responder_pkg.sv
// Shared types and bus widths for the Wishbone SRAM responder.
// State encoding for the responder FSM lives here.
package team_06_wb_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_AW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_state_t;

endpackage

// File: rtl/team_06_wb_sram_responder_if.sv
// Wishbone classic bus bundle between manager and responder.
// Signal names follow the slave-side view (wbs_*_i / wbs_*_o).
interface team_06_wb_sram_responder_if;
    import team_06_wb_pkg::*;

    logic               wbs_cyc_i;
    logic               wbs_stb_i;
    logic               wbs_we_i;
    logic [WB_SELW-1:0] wbs_sel_i;
    logic [WB_AW-1:0]   wbs_adr_i;
    logic [WB_DW-1:0]   wbs_dat_i;
    logic               wbs_ack_o;
    logic               wbs_err_o;
    logic [WB_DW-1:0]   wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i,
        output wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_err_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
        input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_err_o, wbs_dat_o
    );

endinterface

// File: rtl/team_06_wb_sram_responder_sram.sv
// DEPTH x 32 sample store: byte-enable write, registered read.
// Contents are intentionally never reset.
module team_06_sram_bank
    import team_06_wb_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               we,
    input  logic [WB_SELW-1:0] be,
    input  logic [IW-1:0]      waddr,
    input  logic [WB_DW-1:0]   wdata,
    input  logic [IW-1:0]      raddr,
    output logic [WB_DW-1:0]   rdata
);

    logic [WB_DW-1:0] mem [DEPTH];

    // Per-lane write plus a read port that samples every cycle.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < WB_SELW; b++) begin
            if (we && be[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/team_06_wb_sram_responder.sv
// Wishbone classic responder with fixed wait states over an SRAM bank.
// Optional macro TEAM_06_WB_ERR_EN: out-of-range accesses answer with ERR.
module team_06_wb_sram_responder
    import team_06_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
    parameter int          DEPTH       = 16384,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    team_06_wb_sram_responder_if.slave   wb,
    output logic [15:0]                  txn_count_o
);

    localparam int          IW        = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    wb_state_t          state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IW-1:0]      idx_q;
    logic [WB_DW-1:0]   wdat_q;
    logic [WB_SELW-1:0] sel_q;
    logic               we_q;
    logic               hit_q;
    logic [WB_DW-1:0]   hold_q;

    logic [29:0]        word_off;
    logic               hit;
    logic [IW-1:0]      idx;
    logic               accept;
    logic               fire;
    logic               rd_load;
    logic [WB_DW-1:0]   bank_rdata;
    logic [WB_DW-1:0]   rd_val;
    logic [IW-1:0]      raddr;

    assign word_off = 30'((wb.wbs_adr_i - BASE_ADDR) >> 2);
    assign hit      = (wb.wbs_adr_i >= BASE_ADDR) && (word_off < DEPTH_W);
    assign idx      = word_off[IW-1:0];
    assign accept   = (state_q == IDLE) && wb.wbs_cyc_i && wb.wbs_stb_i;
    assign fire     = (state_q == RESP) && wb.wbs_cyc_i;

`ifdef TEAM_06_WB_ERR_EN
    assign wb.wbs_ack_o = fire && hit_q;
    assign wb.wbs_err_o = fire && !hit_q;
    assign rd_load      = fire && !we_q && hit_q;
`else
    assign wb.wbs_ack_o = fire;
    assign wb.wbs_err_o = 1'b0;
    assign rd_load      = fire && !we_q;
`endif

    // Read the incoming word on the accept edge so zero-wait reads work.
    assign raddr  = (state_q == IDLE) ? idx : idx_q;
    assign rd_val = hit_q ? bank_rdata : '0;

    assign wb.wbs_dat_o = rd_load ? rd_val : hold_q;

    team_06_sram_bank #(
        .DEPTH (DEPTH)
    ) u_bank (
        .CLK   (CLK),
        .we    (fire && we_q && hit_q),
        .be    (sel_q),
        .waddr (idx_q),
        .wdata (wdat_q),
        .raddr (raddr),
        .rdata (bank_rdata)
    );

    // Next-state and wait counter; a dropped cyc aborts from any busy state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!wb.wbs_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture: bus inputs are only looked at on the accept edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idx_q  <= '0;
            wdat_q <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
            hit_q  <= 1'b0;
        end else if (accept) begin
            idx_q  <= idx;
            wdat_q <= wb.wbs_dat_i;
            sel_q  <= wb.wbs_sel_i;
            we_q   <= wb.wbs_we_i;
            hit_q  <= hit;
        end
    end

    // Read data holds from one read acknowledge to the next.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hold_q <= '0;
        end else if (rd_load) begin
            hold_q <= rd_val;
        end
    end

    // Saturating count of completed transfers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            txn_count_o <= '0;
        end else if ((wb.wbs_ack_o || wb.wbs_err_o) && (txn_count_o != 16'hFFFF)) begin
            txn_count_o <= txn_count_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_team_06_wb_sram_responder.sv
// Directed bench for team_06_wb_sram_responder (WAIT_CYCLES=2).
// Honours TEAM_06_WB_ERR_EN when it is defined for the build.
module tb_team_06_wb_sram_responder;
    import team_06_wb_pkg::*;

    localparam logic [31:0] BASE  = 32'h3300_0000;
    localparam int          DEPTH = 16384;
    localparam int          WAITC = 2;
`ifdef TEAM_06_WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        bit          oor;
        logic [31:0] exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [15:0] txn_count;
    int          total = 0;
    int          bad = 0;
    int          exp_cnt = 0;
    logic [31:0] last_rd = '0;
    vec_t        vt[$];

    team_06_wb_sram_responder_if bus();

    team_06_wb_sram_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .wb          (bus.slave),
        .txn_count_o (txn_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
    endtask

    task automatic drive(input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
    endtask

    task automatic xfer(input string tag, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] wdat,
                        input bit oor, input logic [31:0] exp_rd);
        int          n;
        bit          got;
        logic        s_ack, s_err;
        logic [31:0] s_dat, want;
        n = 0;
        got = 1'b0;
        s_ack = 1'b0;
        s_err = 1'b0;
        s_dat = '0;
        @(negedge CLK);
        drive(we, sel, adr, wdat);
        while (!got && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
            if (bus.wbs_ack_o || bus.wbs_err_o) begin
                got   = 1'b1;
                s_ack = bus.wbs_ack_o;
                s_err = bus.wbs_err_o;
                s_dat = bus.wbs_dat_o;
            end
        end
        check({tag, " latency"}, 32'(n), 32'(WAITC + 1));
        check({tag, " ack"}, 32'(s_ack), 32'(!(oor && ERR_EN)));
        check({tag, " err"}, 32'(s_err), 32'(oor && ERR_EN));
        exp_cnt++;
        if (!we) begin
            if (oor) want = ERR_EN ? last_rd : 32'h0;
            else     want = exp_rd;
            check({tag, " rdata"}, s_dat, want);
            last_rd = want;
        end
        @(posedge CLK);
        #1;
        check({tag, " ack width"}, 32'(bus.wbs_ack_o || bus.wbs_err_o), 32'h0);
        check({tag, " count"}, 32'(txn_count), 32'(exp_cnt));
        idle_bus();
    endtask

    initial begin
        int          t1, t2, nack;
        bit          seen;
        idle_bus();
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset count", 32'(txn_count), 32'h0);
        check("reset ack", 32'(bus.wbs_ack_o), 32'h0);
        check("reset dat", bus.wbs_dat_o, 32'h0);
        nRST = 1'b1;

        xfer("pre wr", 1'b1, 4'hF, BASE + 32'd12, 32'h0BAD_F00D, 1'b0, '0);
        xfer("pre rd", 1'b0, 4'hF, BASE + 32'd12, '0, 1'b0, 32'h0BAD_F00D);

        // Asynchronous reset while the write sits in WAIT.
        @(negedge CLK);
        drive(1'b1, 4'hF, BASE + 32'd12, 32'hCAFE_F00D);
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        check("rst wait ack", 32'(bus.wbs_ack_o), 32'h0);
        check("rst wait dat", bus.wbs_dat_o, 32'h0);
        check("rst wait count", 32'(txn_count), 32'h0);
        idle_bus();
        @(negedge CLK);
        nRST = 1'b1;
        exp_cnt = 0;
        last_rd = '0;

        vt.push_back('{1'b1, 4'hF, BASE,                          32'hDEAD_BEEF, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'hF, BASE,                          32'h0,         1'b0, 32'hDEAD_BEEF});
        vt.push_back('{1'b1, 4'hF, BASE + 32'd4,                  32'h0,         1'b0, 32'h0});
        vt.push_back('{1'b1, 4'h2, BASE + 32'd4,                  32'h0000_AA00, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'hF, BASE + 32'd4,                  32'h0,         1'b0, 32'h0000_AA00});
        vt.push_back('{1'b1, 4'h0, BASE + 32'd4,                  32'h0000_00FF, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'hF, BASE + 32'd4,                  32'h0,         1'b0, 32'h0000_AA00});
        vt.push_back('{1'b0, 4'hF, BASE + 32'(4 * DEPTH),         32'h0,         1'b1, 32'h0});
        vt.push_back('{1'b0, 4'hF, BASE - 32'd4,                  32'h0,         1'b1, 32'h0});
        vt.push_back('{1'b1, 4'hF, BASE + 32'd8,                  32'hA5A5_A5A5, 1'b0, 32'h0});
        vt.push_back('{1'b1, 4'h5, BASE + 32'd8,                  32'h1122_3344, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'hF, BASE + 32'd8,                  32'h0,         1'b0, 32'hA522_A544});
        vt.push_back('{1'b0, 4'h0, BASE,                          32'h0,         1'b0, 32'hDEAD_BEEF});
        vt.push_back('{1'b0, 4'hF, BASE + 32'd3,                  32'h0,         1'b0, 32'hDEAD_BEEF});
        vt.push_back('{1'b1, 4'hF, BASE + 32'(4 * (DEPTH - 1)),   32'h1234_5678, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'hF, BASE + 32'(4 * (DEPTH - 1) + 2), 32'h0,       1'b0, 32'h1234_5678});
        vt.push_back('{1'b1, 4'hF, BASE + 32'(4 * DEPTH + 8),     32'hFFFF_FFFF, 1'b1, 32'h0});
        vt.push_back('{1'b0, 4'hF, BASE + 32'd8,                  32'h0,         1'b0, 32'hA522_A544});

        foreach (vt[i]) begin
            xfer($sformatf("vec%0d", i), vt[i].we, vt[i].sel, vt[i].adr,
                 vt[i].wdat, vt[i].oor, vt[i].exp);
        end

        // Write aborted by dropping cyc one cycle after accept.
        xfer("abort pre", 1'b1, 4'hF, BASE + 32'd16, 32'h1357_2468, 1'b0, '0);
        @(negedge CLK);
        drive(1'b1, 4'hF, BASE + 32'd16, 32'hFFFF_FFFF);
        @(posedge CLK);
        #1;
        idle_bus();
        seen = 1'b0;
        repeat (6) begin
            @(posedge CLK);
            #1;
            if (bus.wbs_ack_o || bus.wbs_err_o) seen = 1'b1;
        end
        check("abort no ack", 32'(seen), 32'h0);
        check("abort count", 32'(txn_count), 32'(exp_cnt));
        xfer("abort rd", 1'b0, 4'hF, BASE + 32'd16, '0, 1'b0, 32'h1357_2468);

        // Strobe without a bus cycle must be ignored.
        @(negedge CLK);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = BASE;
        seen = 1'b0;
        repeat (6) begin
            @(posedge CLK);
            #1;
            if (bus.wbs_ack_o || bus.wbs_err_o) seen = 1'b1;
        end
        idle_bus();
        check("stb only ack", 32'(seen), 32'h0);
        check("stb only count", 32'(txn_count), 32'(exp_cnt));

        // Back-to-back reads with cyc/stb held: period is WAITC+2.
        @(negedge CLK);
        drive(1'b0, 4'hF, BASE, '0);
        t1 = -1;
        t2 = -1;
        nack = 0;
        for (int c = 1; c <= 20 && nack < 2; c++) begin
            @(posedge CLK);
            #1;
            if (bus.wbs_ack_o) begin
                nack++;
                if (nack == 1) t1 = c;
                else           t2 = c;
                check($sformatf("b2b rd%0d", nack), bus.wbs_dat_o, 32'hDEAD_BEEF);
            end
        end
        @(posedge CLK);
        #1;
        idle_bus();
        exp_cnt += 2;
        check("b2b first", 32'(t1), 32'(WAITC + 1));
        check("b2b period", 32'(t2 - t1), 32'(WAITC + 2));
        check("b2b count", 32'(txn_count), 32'(exp_cnt));

        // The write cut off by reset never landed.
        xfer("rst word", 1'b0, 4'hF, BASE + 32'd12, '0, 1'b0, 32'h0BAD_F00D);

        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
